// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multicycle core: opcodes, stage encodings and
// instruction field positions.
package cpu_mc_pkg;

  localparam int INST_W  = 16;
  localparam int FIELD_W = 4;
  localparam int IMM_W   = 8;

  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RA_LSB  = 4;
  localparam int RB_LSB  = 0;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SHR  = 4'h2;
  localparam logic [3:0] OP_SHL  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_JAL  = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_LDI  = 4'hC;
  localparam logic [3:0] OP_ADDI = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_F = 3'd0,
    ST_D = 3'd1,
    ST_X = 3'd2,
    ST_M = 3'd3,
    ST_W = 3'd4
  } stage_e;

  function automatic logic [FIELD_W-1:0] field4(input logic [INST_W-1:0] inst,
                                                input int lsb);
    return inst[lsb +: FIELD_W];
  endfunction

  function automatic logic [IMM_W-1:0] imm8(input logic [INST_W-1:0] inst);
    return inst[IMM_LSB +: IMM_W];
  endfunction

  // Opcodes whose W stage commits a value into RD.
  function automatic logic writes_rd(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_OR, OP_AND, OP_NOT, OP_XOR,
      OP_JAL, OP_LD, OP_LDI, OP_ADDI:    return 1'b1;
      OP_BZ, OP_ST, OP_NOP, OP_HALT:     return 1'b0;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_mc_alu.sv
// Combinational DW-wide ALU for the eight register-register operations;
// shift counts use the full RB value and saturate to zero at DW or more.
module cpu_mc_alu
  import cpu_mc_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y,
  output logic          zero
);

  localparam logic [DW-1:0] SHIFT_LIMIT = DW'(DW);

  logic big_shift;
  assign big_shift = (b >= SHIFT_LIMIT);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD[2:0]: y = a + b;
      OP_SUB[2:0]: y = a - b;
      OP_SHR[2:0]: y = big_shift ? '0 : (a >> b);
      OP_SHL[2:0]: y = big_shift ? '0 : (a << b);
      OP_OR[2:0]:  y = a | b;
      OP_AND[2:0]: y = a & b;
      OP_NOT[2:0]: y = ~a;
      OP_XOR[2:0]: y = a ^ b;
      default:     y = '0;
    endcase
    zero = (y == '0);
  end

endmodule

// File: rtl/cpu_mc_param.sv
// Parametrised multicycle core: F -> D -> X -> [M] -> W, with a DREQ/DRDY
// wait-state handshake to data memory and a tri-stated data bus.
module cpu_mc_param
  import cpu_mc_pkg::*;
#(
  parameter int          DW       = 16,
  parameter int          AW       = 16,
  parameter int          NREG     = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic              CK,
  input  logic              RST,
  output logic [AW-1:0]     IA,
  input  logic [INST_W-1:0] ID,
  output logic [AW-1:0]     DA,
  inout  wire  [DW-1:0]     DD,
  output logic              RW,
  output logic              DREQ,
  input  logic              DRDY,
  output logic              HALT
);

  stage_e            stage_q, stage_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [DW-1:0]     a_q, a_d;
  logic [DW-1:0]     b_q, b_d;
  logic [DW-1:0]     res_q, res_d;
  logic              alu_z_q, alu_z_d;
  logic              z_q, z_d;
  logic              halt_q, halt_d;
  logic [DW-1:0]     rf_q [NREG];
  logic [DW-1:0]     rf_d [NREG];

  logic [3:0]        op, rd, ra, rb;
  logic [IMM_W-1:0]  imm;
  logic [AW-1:0]     pc_inc;
  logic [DW-1:0]     ra_val, rb_val, rd_val;
  logic              rd_ok;
  logic [DW-1:0]     alu_y;
  logic              alu_zero;

  assign op     = field4(inst_q, OP_LSB);
  assign rd     = field4(inst_q, RD_LSB);
  assign ra     = field4(inst_q, RA_LSB);
  assign rb     = field4(inst_q, RB_LSB);
  assign imm    = imm8(inst_q);
  assign pc_inc = pc_q + AW'(1);

  // Out-of-range register numbers read as zero; R0 is hard-wired to zero.
  always_comb begin
    ra_val = (int'(ra) < NREG && ra != '0) ? rf_q[ra] : '0;
    rb_val = (int'(rb) < NREG && rb != '0) ? rf_q[rb] : '0;
    rd_val = (int'(rd) < NREG && rd != '0) ? rf_q[rd] : '0;
    rd_ok  = (int'(rd) < NREG) && (rd != '0);
  end

  cpu_mc_alu #(.DW(DW)) u_alu (
    .op   (inst_q[OP_LSB +: 3]),
    .a    (a_q),
    .b    (b_q),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // Stage register
  always_ff @(posedge CK or posedge RST) begin
    if (RST) stage_q <= ST_F;
    else     stage_q <= stage_d;
  end

  // Next-stage logic; a halted core parks in F and never fetches again.
  always_comb begin
    stage_d = stage_q;
    unique case (stage_q)
      ST_F:    if (!halt_q) stage_d = ST_D;
      ST_D:    stage_d = ST_X;
      ST_X:    stage_d = (op == OP_LD || op == OP_ST) ? ST_M : ST_W;
      ST_M:    if (DRDY) stage_d = ST_W;
      ST_W:    stage_d = ST_F;
      default: stage_d = ST_F;
    endcase
  end

  // Bus outputs are decoded from the stage so reset releases them at once.
  always_comb begin
    DREQ = (stage_q == ST_M);
    RW   = !((stage_q == ST_M) && (op == OP_ST));
  end

  assign DD   = RW ? {DW{1'bz}} : a_q;
  assign DA   = b_q[AW-1:0];
  assign IA   = pc_q;
  assign HALT = halt_q;

  always_comb begin
    // NOTE: every *_d starts as its *_q so no path through this block can
    // leave a value unassigned and infer a latch.
    pc_d    = pc_q;
    inst_d  = inst_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    alu_z_d = alu_z_q;
    z_d     = z_q;
    halt_d  = halt_q;
    rf_d    = rf_q;

    case (stage_q)
      ST_F: if (!halt_q) inst_d = ID;
      ST_D: begin
        // ADDI accumulates into RD, so RD rides the A operand path.
        a_d = (op == OP_ADDI) ? rd_val : ra_val;
        b_d = rb_val;
      end
      ST_X: begin
        alu_z_d = alu_zero;
        case (op)
          OP_JAL:  res_d = DW'(pc_inc);
          OP_LDI:  res_d = DW'(imm);
          OP_ADDI: res_d = a_q + DW'($signed(imm));
          default: res_d = alu_y;
        endcase
      end
      ST_M: if (op == OP_LD && DRDY) res_d = DD;
      ST_W: begin
        if (writes_rd(op) && rd_ok) rf_d[rd] = res_q;
        if (op[3] == 1'b0) z_d = alu_z_q;
        // Branch targets come from the B operand latched in D, so JAL with
        // RD == RB still jumps to the old RB value.
        case (op)
          OP_JAL:  pc_d = b_q[AW-1:0];
          OP_BZ:   pc_d = z_q ? b_q[AW-1:0] : pc_inc;
          OP_HALT: halt_d = 1'b1;
          default: pc_d = pc_inc;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      // NOTE: the register file lives in flops rather than a RAM macro so it
      // can be cleared by the asynchronous reset like every other state bit.
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      alu_z_q <= 1'b0;
      z_q     <= 1'b0;
      halt_q  <= 1'b0;
      rf_q    <= '{default: '0};
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values computed by the combinational blocks.
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      alu_z_q <= alu_z_d;
      z_q     <= z_d;
      halt_q  <= halt_d;
      rf_q    <= rf_d;
    end
  end

endmodule

// File: tb/tb_cpu_mc_param.sv
// Directed bench for cpu_mc_param: program ROM, wait-state data memory model
// and hand-computed results observed through stores, branches and IA.
module tb_cpu_mc_param;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ia, da, id;
  wire  [15:0] dd;
  logic        rw, dreq, halt;
  logic        drdy = 1'b0;

  logic [15:0] rom [0:255];

  int          wait_cfg  = 0;
  logic [15:0] rdata_cfg = 16'h0000;
  int          m_cnt     = 0;
  logic        mem_en    = 1'b0;
  logic [15:0] mem_val   = 16'h0000;
  logic        probe_en  = 1'b0;
  logic [15:0] probe_val = 16'h0000;

  int          wr_cnt  = 0;
  logic [15:0] wr_addr = 16'h0000;
  logic [15:0] wr_data = 16'h0000;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 ck = ~ck;

  assign id = (ia < 16'd256) ? rom[ia[7:0]] : 16'hE000;
  assign dd = probe_en ? probe_val : (mem_en ? mem_val : 16'hzzzz);

  cpu_mc_param #(.DW(16), .AW(16), .NREG(16), .RESET_PC(16'h0000)) dut (
    .CK   (ck),
    .RST  (rst),
    .IA   (ia),
    .ID   (id),
    .DA   (da),
    .DD   (dd),
    .RW   (rw),
    .DREQ (dreq),
    .DRDY (drdy),
    .HALT (halt)
  );

  // Data memory: DRDY rises after wait_cfg request cycles; reads drive rdata_cfg.
  always @(negedge ck) begin
    if (dreq) begin
      drdy    = (m_cnt >= wait_cfg);
      m_cnt   = m_cnt + 1;
      mem_en  = rw;
      mem_val = rdata_cfg;
    end else begin
      drdy   = 1'b0;
      m_cnt  = 0;
      mem_en = 1'b0;
    end
  end

  always @(posedge ck) begin
    if (dreq && drdy && !rw) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = da;
      wr_data = dd;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic wait_ia(input string tag, input logic [15:0] target, input int budget);
    int i = 0;
    while (ia !== target && i < budget) begin
      @(negedge ck);
      i++;
    end
    check(tag, {16'h0, ia}, {16'h0, target});
  endtask

  task automatic expect_wr(input string tag, input logic [15:0] data, input int budget);
    int start = wr_cnt;
    int i = 0;
    while (wr_cnt == start && i < budget) begin
      @(negedge ck);
      i++;
    end
    check(tag, {16'h0, wr_data}, {16'h0, data});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;

    for (int i = 0; i < 256; i++) rom[i] = 16'hE000;
    rom[8'h00] = 16'hC105; rom[8'h01] = 16'hC203; rom[8'h02] = 16'h1312;
    rom[8'h03] = 16'hB032; rom[8'h04] = 16'hC520; rom[8'h05] = 16'h9005;
    rom[8'h06] = 16'h1411; rom[8'h07] = 16'h9005; rom[8'h08] = 16'hF000;
    rom[8'h20] = 16'hB012; rom[8'h21] = 16'hA602; rom[8'h22] = 16'hC730;
    rom[8'h23] = 16'h9007; rom[8'h24] = 16'hF000;
    rom[8'h30] = 16'hB062; rom[8'h31] = 16'hC901; rom[8'h32] = 16'h4099;
    rom[8'h33] = 16'hC810; rom[8'h34] = 16'h3A98; rom[8'h35] = 16'hB0A2;
    rom[8'h36] = 16'hCB40; rom[8'h37] = 16'h900B; rom[8'h38] = 16'hF000;
    rom[8'h40] = 16'hD1FF; rom[8'h41] = 16'hB012; rom[8'h42] = 16'hC077;
    rom[8'h43] = 16'hB002; rom[8'h44] = 16'hCD50; rom[8'h45] = 16'h8D0D;
    rom[8'h50] = 16'hB0D2; rom[8'h51] = 16'h6E00; rom[8'h52] = 16'hB0E2;
    rom[8'h53] = 16'h0FE9; rom[8'h54] = 16'hB0F2; rom[8'h55] = 16'h73E1;
    rom[8'h56] = 16'hB032; rom[8'h57] = 16'hB012;

    rst = 1'b1;
    @(negedge ck);
    check("rst_ia",   {16'h0, ia}, 32'h0);
    check("rst_halt", {31'h0, halt}, 32'h0);
    check("rst_dreq", {31'h0, dreq}, 32'h0);
    check("rst_rw",   {31'h0, rw}, 32'h1);
    rst = 1'b0;

    // LDI / LDI / SUB: one instruction every four cycles
    repeat (4) @(negedge ck);
    check("ia_after_1", {16'h0, ia}, 32'h1);
    repeat (4) @(negedge ck);
    check("ia_after_2", {16'h0, ia}, 32'h2);
    repeat (4) @(negedge ck);
    check("ia_after_3", {16'h0, ia}, 32'h3);
    expect_wr("sub_r3", 16'h0002, 40);
    check("st_addr", {16'h0, wr_addr}, 32'h3);

    wait_ia("bz_not_taken", 16'h0006, 40);
    wait_ia("bz_taken", 16'h0020, 40);

    // ST with three wait states
    wait_cfg = 3;
    n = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ck);
      if (dreq) seen = 1;
      if (dreq && !rw && dd == 16'h0005) n++;
      if (seen != 0 && !dreq) break;
    end
    check("st_m_cycles", n, 4);
    check("st_rw_after", {31'h0, rw}, 32'h1);
    check("st_dreq_after", {31'h0, dreq}, 32'h0);
    check("st_wdata", {16'h0, wr_data}, 32'h5);

    // LD with two wait states, then BZ proves Z survived ST/LD/LDI
    wait_cfg  = 2;
    rdata_cfg = 16'hBEEF;
    wait_ia("z_held_ldst", 16'h0030, 80);
    wait_cfg = 0;
    expect_wr("ld_beef", 16'hBEEF, 40);
    expect_wr("shl16_val", 16'h0000, 60);
    wait_ia("shl16_z", 16'h0040, 60);
    expect_wr("addi_m1", 16'h0004, 40);
    expect_wr("r0_zero", 16'h0000, 40);
    wait_ia("jal_target", 16'h0050, 60);
    expect_wr("jal_link", 16'h0046, 40);
    expect_wr("not_r0", 16'hFFFF, 40);
    expect_wr("add_wrap", 16'h0000, 40);
    expect_wr("xor", 16'hFFFB, 40);

    // Reset in the middle of a stalled ST; restart hits a HALT at RESET_PC
    wait_cfg   = 8;
    rom[8'h00] = 16'hF000;
    for (int i = 0; i < 40 && !dreq; i++) @(negedge ck);
    check("mst_dreq", {31'h0, dreq}, 32'h1);
    @(negedge ck);
    check("mst_rw", {31'h0, rw}, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("arst_rw",   {31'h0, rw}, 32'h1);
    check("arst_dreq", {31'h0, dreq}, 32'h0);
    check("arst_ia",   {16'h0, ia}, 32'h0);
    probe_en  = 1'b1;
    probe_val = 16'h1234;
    #1;
    check("arst_dd_released", {16'h0, dd}, 32'h1234);
    probe_en = 1'b0;
    wait_cfg = 0;
    repeat (2) @(negedge ck);
    rst = 1'b0;

    repeat (4) @(negedge ck);
    check("halt_set", {31'h0, halt}, 32'h1);
    check("halt_ia", {16'h0, ia}, 32'h0);
    repeat (10) @(negedge ck);
    check("halt_ia_frozen", {16'h0, ia}, 32'h0);
    check("halt_held", {31'h0, halt}, 32'h1);
    check("halt_no_dreq", {31'h0, dreq}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
